// File: rtl/led_game_pkg.sv
// Shared types and helpers for the LED lane game: obstacle slot record,
// the obstacle LFSR step and the lane-to-column mapping.
package led_game_pkg;

    // Widest lane index any configuration can use; unused upper bits stay zero.
    localparam int LANE_MAX_W = 14;

    // Galois feedback mask for taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One obstacle slot: whether it holds an obstacle and which lane it is in.
    typedef struct packed {
        logic                  valid;
        logic [LANE_MAX_W-1:0] lane;
    } slot_t;

    // Advance the obstacle LFSR by one step.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

    // Lanes are spread evenly across the columns; shift = column bits minus lane bits.
    function automatic logic [15:0] lane_to_x(input logic [LANE_MAX_W-1:0] lane, input int shift);
        return 16'(lane) << shift;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Tick generator: counts enabled cycles and fires once the count reaches limit.
// The compare is >= so that lowering limit mid-period fires on the next cycle.
module led_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable,
    input  logic [DIV_W-1:0] limit,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = enable && (count >= limit);

    // Count while enabled, clear on the tick, hold while disabled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (enable) begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_lane_scroller.sv
// Lane scroller game core: obstacles fall down a set of lanes in slots of
// rows, the player sits on the bottom row, and the field is scanned out one
// pixel coordinate per scan tick for the LED matrix driver.
module led_lane_scroller
    import led_game_pkg::*;
#(
    parameter int          X_W        = 3,
    parameter int          Y_W        = 4,
    parameter int          RPS_W      = 2,
    parameter int          LANE_W     = 2,
    parameter int          SCAN_DIV   = 10000,
    parameter int          SCROLL_DIV = 3000000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pause,
    input  logic              restart,
    input  logic [1:0]        speed,
    input  logic [LANE_W-1:0] player_lane,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic              pix_valid,
    output logic              frame_start,
    output logic              game_over,
    output logic [15:0]       score
);

    localparam int ROWS       = 2 ** Y_W;
    localparam int SLOT_W     = Y_W - RPS_W;
    localparam int SLOTS      = 2 ** SLOT_W;
    localparam int LANE_SHIFT = X_W - LANE_W;
    localparam int STEP_W     = Y_W + 1;
    localparam int SCAN_W     = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
    localparam int SCROLL_W   = (SCROLL_DIV < 1) ? 1 : $clog2(SCROLL_DIV + 1);

    logic                scan_tick;
    logic                scroll_tick;
    logic                scroll_enable;
    logic                scroll_clear;
    logic [SCROLL_W-1:0] scroll_limit;

    slot_t               slots    [SLOTS];
    slot_t               slots_nx [SLOTS];
    logic [SLOT_W-1:0]   head, head_nx;
    logic [RPS_W-1:0]    offset, offset_nx;
    logic [15:0]         lfsr, lfsr_nx;
    logic [15:0]         score_nx;
    logic                game_over_nx;
    slot_t               bottom;
    logic                at_last;

    logic [STEP_W-1:0]   step;
    logic [Y_W-1:0]      scan_row;
    logic [SLOT_W-1:0]   scan_phys;
    slot_t               scan_entry;
    logic                scan_hit;

    assign scroll_enable = !pause && !game_over;
    assign scroll_clear  = RST || restart;
    assign scroll_limit  = SCROLL_W'(SCROLL_DIV) >> speed;

    led_prescaler #(.DIV_W(SCAN_W)) u_scan_div (
        .CLK    (CLK),
        .RST    (RST),
        .enable (1'b1),
        .limit  (SCAN_W'(SCAN_DIV)),
        .tick   (scan_tick)
    );

    led_prescaler #(.DIV_W(SCROLL_W)) u_scroll_div (
        .CLK    (CLK),
        .RST    (scroll_clear),
        .enable (scroll_enable),
        .limit  (scroll_limit),
        .tick   (scroll_tick)
    );

    // Look up the slot covering the row currently being scanned and whether its obstacle sits on that row.
    always_comb begin
        scan_row   = {Y_W{1'b1}} - step[Y_W-1:0];
        scan_phys  = head + scan_row[Y_W-1:RPS_W];
        scan_entry = slots[scan_phys];
        scan_hit   = scan_entry.valid && (scan_row[RPS_W-1:0] == ({RPS_W{1'b1}} - offset));
    end

    // Scan sequencer: rows top to bottom, then one step for the player pixel; outputs change only on scan ticks.
    always_ff @(posedge CLK) begin
        if (RST) begin
            step        <= '0;
            x_out       <= '0;
            y_out       <= '1;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (scan_tick) begin
                if (step == STEP_W'(ROWS)) begin
                    step      <= '0;
                    x_out     <= X_W'(lane_to_x(LANE_MAX_W'(player_lane), LANE_SHIFT));
                    y_out     <= '0;
                    pix_valid <= 1'b1;
                end else begin
                    step        <= step + STEP_W'(1);
                    x_out       <= X_W'(lane_to_x(scan_entry.lane, LANE_SHIFT));
                    y_out       <= scan_row;
                    pix_valid   <= scan_hit;
                    frame_start <= (step == '0);
                end
            end
        end
    end

    // Game next-state: restart wipes the field, otherwise a scroll tick either collides, retires the bottom slot or steps the offset.
    always_comb begin
        slots_nx     = slots;
        head_nx      = head;
        offset_nx    = offset;
        lfsr_nx      = lfsr;
        score_nx     = score;
        game_over_nx = game_over;
        bottom       = slots[head];
        at_last      = (offset == {RPS_W{1'b1}});

        if (restart) begin
            for (int i = 0; i < SLOTS; i++) begin
                slots_nx[i] = '0;
            end
            head_nx      = '0;
            offset_nx    = '0;
            score_nx     = '0;
            game_over_nx = 1'b0;
        end else if (scroll_tick) begin
            if (at_last && bottom.valid && (bottom.lane == LANE_MAX_W'(player_lane))) begin
                game_over_nx = 1'b1;
            end else if (at_last) begin
                if (bottom.valid && (score != 16'hFFFF)) begin
                    score_nx = score + 16'd1;
                end
                slots_nx[head].valid = lfsr[1] | lfsr[0];
                slots_nx[head].lane  = LANE_MAX_W'(lfsr[LANE_W+1:2]);
                head_nx              = head + SLOT_W'(1);
                lfsr_nx              = lfsr_next(lfsr);
                offset_nx            = '0;
            end else begin
                offset_nx = offset + RPS_W'(1);
            end
        end
    end

    // Game state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SLOTS; i++) begin
                slots[i] <= '0;
            end
            head      <= '0;
            offset    <= '0;
            lfsr      <= LFSR_SEED;
            score     <= '0;
            game_over <= 1'b0;
        end else begin
            slots     <= slots_nx;
            head      <= head_nx;
            offset    <= offset_nx;
            lfsr      <= lfsr_nx;
            score     <= score_nx;
            game_over <= game_over_nx;
        end
    end

endmodule

// File: tb/tb_led_lane_scroller.sv
// Self-checking bench for led_lane_scroller with fast prescalers
// (SCAN_DIV=1, SCROLL_DIV=7). A behavioural model of the game predicts every
// cycle's outputs into a scoreboard queue; a table covers the first frame and
// directed sequences cover collision, pause, speed, restart and saturation.
module tb_led_lane_scroller;

    localparam int SCAN_DIV   = 1;
    localparam int SCROLL_DIV = 7;
    localparam int ROWS       = 16;
    localparam int RPS        = 4;
    localparam int SLOTS      = 4;

    logic        CLK         = 1'b0;
    logic        RST         = 1'b1;
    logic        pause       = 1'b0;
    logic        restart     = 1'b0;
    logic [1:0]  speed       = 2'd0;
    logic [1:0]  player_lane = 2'd3;
    logic [2:0]  x_out;
    logic [3:0]  y_out;
    logic        pix_valid;
    logic        frame_start;
    logic        game_over;
    logic [15:0] score;

    led_lane_scroller #(
        .X_W        (3),
        .Y_W        (4),
        .RPS_W      (2),
        .LANE_W     (2),
        .SCAN_DIV   (SCAN_DIV),
        .SCROLL_DIV (SCROLL_DIV),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .pause       (pause),
        .restart     (restart),
        .speed       (speed),
        .player_lane (player_lane),
        .x_out       (x_out),
        .y_out       (y_out),
        .pix_valid   (pix_valid),
        .frame_start (frame_start),
        .game_over   (game_over),
        .score       (score)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state; field is kept as a shifting list, index 0 = bottom slot.
    int          m_scan_cnt, m_scroll_cnt, m_step, m_off, m_score, m_clears;
    int          m_valid [SLOTS];
    int          m_lane  [SLOTS];
    logic [15:0] m_lfsr;
    bit          m_go, m_pix, m_fs;
    logic [2:0]  m_x;
    logic [3:0]  m_y;

    typedef struct packed {
        logic [2:0]  x;
        logic [3:0]  y;
        logic        pix;
        logic        fs;
        logic        go;
        logic [15:0] score;
    } obs_t;

    obs_t sb_q[$];

    typedef struct packed {
        logic [1:0] lane;
        logic [2:0] x;
        logic [3:0] y;
        logic       pix;
        logic       fs;
    } vec_t;

    vec_t vecs [18];

    task automatic model_reset();
        m_scan_cnt   = 0;
        m_scroll_cnt = 0;
        m_step       = 0;
        m_off        = 0;
        m_score      = 0;
        m_clears     = 0;
        m_lfsr       = 16'hACE1;
        m_go         = 1'b0;
        m_x          = 3'd0;
        m_y          = 4'd15;
        m_pix        = 1'b0;
        m_fs         = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            m_valid[i] = 0;
            m_lane[i]  = 0;
        end
    endtask

    task automatic model_scroll();
        if (m_off == RPS - 1) begin
            if (m_valid[0] != 0 && m_lane[0] == int'(player_lane)) begin
                m_go = 1'b1;
            end else begin
                if (m_valid[0] != 0) begin
                    m_clears++;
                    if (m_score < 65535) m_score++;
                end
                for (int i = 0; i < SLOTS - 1; i++) begin
                    m_valid[i] = m_valid[i+1];
                    m_lane[i]  = m_lane[i+1];
                end
                m_valid[SLOTS-1] = int'(m_lfsr[0] | m_lfsr[1]);
                m_lane[SLOTS-1]  = int'((m_lfsr >> 2) & 16'h3);
                m_lfsr           = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
                m_off            = 0;
            end
        end else begin
            m_off++;
        end
    endtask

    task automatic model_step();
        bit scan_tick, scroll_en, scroll_tick;
        int lim, y, s, sub;
        if (RST) begin
            model_reset();
            return;
        end
        scan_tick   = (m_scan_cnt == SCAN_DIV);
        lim         = SCROLL_DIV >> speed;
        scroll_en   = !pause && !m_go;
        scroll_tick = scroll_en && (m_scroll_cnt >= lim);
        m_fs        = 1'b0;
        if (scan_tick) begin
            if (m_step == ROWS) begin
                m_x    = 3'(int'(player_lane) * 2);
                m_y    = 4'd0;
                m_pix  = 1'b1;
                m_step = 0;
            end else begin
                y      = ROWS - 1 - m_step;
                s      = y / RPS;
                sub    = y % RPS;
                m_y    = 4'(y);
                m_x    = 3'(m_lane[s] * 2);
                m_pix  = (m_valid[s] != 0) && (sub == RPS - 1 - m_off);
                m_fs   = (m_step == 0);
                m_step++;
            end
            m_scan_cnt = 0;
        end else begin
            m_scan_cnt++;
        end
        if (restart) begin
            for (int i = 0; i < SLOTS; i++) begin
                m_valid[i] = 0;
                m_lane[i]  = 0;
            end
            m_off        = 0;
            m_score      = 0;
            m_go         = 1'b0;
            m_scroll_cnt = 0;
        end else if (scroll_tick) begin
            m_scroll_cnt = 0;
            model_scroll();
        end else if (scroll_en) begin
            m_scroll_cnt++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: advance the model, queue its prediction, compare the DUT just after the edge.
    task automatic tick_clk();
        obs_t exp_o, act_o;
        @(posedge CLK);
        model_step();
        exp_o.x     = m_x;
        exp_o.y     = m_y;
        exp_o.pix   = m_pix;
        exp_o.fs    = m_fs;
        exp_o.go    = m_go;
        exp_o.score = m_score[15:0];
        sb_q.push_back(exp_o);
        #1;
        act_o.x     = x_out;
        act_o.y     = y_out;
        act_o.pix   = pix_valid;
        act_o.fs    = frame_start;
        act_o.go    = game_over;
        act_o.score = score;
        exp_o       = sb_q.pop_front();
        n_checks++;
        if (act_o !== exp_o) begin
            n_fail++;
            $display("[TB] FAIL scan t=%0t: got x=%0d y=%0d pix=%0b fs=%0b go=%0b score=%0d, expected x=%0d y=%0d pix=%0b fs=%0b go=%0b score=%0d",
                     $time, act_o.x, act_o.y, act_o.pix, act_o.fs, act_o.go, act_o.score,
                     exp_o.x, exp_o.y, exp_o.pix, exp_o.fs, exp_o.go, exp_o.score);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) tick_clk();
    endtask

    // Keep the player out of the bottom slot's lane for one clock.
    task automatic dodge_step();
        player_lane = 2'((m_lane[0] + 1) % 4);
        tick_clk();
    endtask

    task automatic budget_fail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got cycle budget expired, expected event", name);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got time limit reached, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   budget;
        int   hold;
        model_reset();

        // First frame after reset with an empty field, then the first loaded obstacle at the top row.
        for (int k = 0; k < 16; k++) begin
            vecs[k] = '{lane: 2'd3, x: 3'd0, y: 4'(15 - k), pix: 1'b0, fs: (k == 0)};
        end
        vecs[16] = '{lane: 2'd3, x: 3'd6, y: 4'd0,  pix: 1'b1, fs: 1'b0};
        vecs[17] = '{lane: 2'd3, x: 3'd0, y: 4'd15, pix: 1'b1, fs: 1'b1};

        $display("[TB] reset");
        applyStimulus(3);
        checkOutput("reset_x", 32'(x_out), 32'd0);
        checkOutput("reset_y", 32'(y_out), 32'd15);
        checkOutput("reset_pix", 32'(pix_valid), 32'd0);
        checkOutput("reset_fs", 32'(frame_start), 32'd0);
        checkOutput("reset_go", 32'(game_over), 32'd0);
        checkOutput("reset_score", 32'(score), 32'd0);
        RST = 1'b0;

        $display("[TB] first frame table");
        for (int i = 0; i < 18; i++) begin
            player_lane = vecs[i].lane;
            applyStimulus(2);
            checkOutput($sformatf("vec%0d_x", i), 32'(x_out), 32'(vecs[i].x));
            checkOutput($sformatf("vec%0d_y", i), 32'(y_out), 32'(vecs[i].y));
            checkOutput($sformatf("vec%0d_pix", i), 32'(pix_valid), 32'(vecs[i].pix));
            checkOutput($sformatf("vec%0d_fs", i), 32'(frame_start), 32'(vecs[i].fs));
        end

        $display("[TB] score to 10");
        budget = 4000;
        while (m_score < 10 && budget > 0) begin
            dodge_step();
            budget--;
        end
        if (budget == 0) budget_fail("score10_wait");
        checkOutput("score_10", 32'(score), 32'd10);

        $display("[TB] pause");
        pause = 1'b1;
        applyStimulus(100);
        pause = 1'b0;
        checkOutput("pause_score", 32'(score), 32'd10);
        checkOutput("pause_go", 32'(game_over), 32'd0);

        $display("[TB] speed changes");
        speed = 2'd2;
        repeat (40) dodge_step();
        speed = 2'd0;
        repeat (5) dodge_step();
        speed = 2'd3;
        repeat (10) dodge_step();
        speed = 2'd1;
        repeat (20) dodge_step();
        speed = 2'd0;
        repeat (3) dodge_step();

        $display("[TB] collision");
        budget = 3000;
        while (!m_go && budget > 0) begin
            if (m_valid[0] != 0) player_lane = 2'(m_lane[0]);
            tick_clk();
            budget--;
        end
        if (budget == 0) budget_fail("collision_wait");
        checkOutput("collide_go", 32'(game_over), 32'd1);
        hold = m_score;
        for (int i = 0; i < 100; i++) begin
            player_lane = 2'(i);
            tick_clk();
        end
        checkOutput("go_sticky", 32'(game_over), 32'd1);
        checkOutput("go_score_hold", 32'(score), 32'(hold));

        $display("[TB] restart");
        restart = 1'b1;
        tick_clk();
        restart = 1'b0;
        checkOutput("restart_go", 32'(game_over), 32'd0);
        checkOutput("restart_score", 32'(score), 32'd0);

        budget = 2000;
        while (m_score < 1 && budget > 0) begin
            dodge_step();
            budget--;
        end
        if (budget == 0) budget_fail("score1_wait");
        budget = 100;
        while (m_scroll_cnt < (SCROLL_DIV >> speed) && budget > 0) begin
            dodge_step();
            budget--;
        end
        if (budget == 0) budget_fail("tick_align_wait");
        restart = 1'b1;
        tick_clk();
        restart = 1'b0;
        checkOutput("restart_tick_score", 32'(score), 32'd0);
        checkOutput("restart_tick_go", 32'(game_over), 32'd0);
        repeat (150) dodge_step();

        $display("[TB] score saturation");
        force dut.score = 16'hFFFF;
        m_score = 65535;
        tick_clk();
        release dut.score;
        hold   = m_clears;
        budget = 3000;
        while (m_clears == hold && budget > 0) begin
            dodge_step();
            budget--;
        end
        if (budget == 0) budget_fail("sat_clear_wait");
        checkOutput("score_sat", 32'(score), 32'hFFFF);
        repeat (10) dodge_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
